// File: rtl/data_cache_port1_controller_if.sv
// Port-1 load sequencer bus: CPU load handshake, tag/data array access and line-fetch memory port.
// master = controller side, slave = CPU/array/memory side.
interface data_cache_port1_controller_if #(
    parameter int unsigned WAYS_NUMBER = 4,
    parameter int unsigned PORT_WIDTH  = 32,
    parameter int unsigned INDEX_SIZE  = 7,
    parameter int unsigned BLOCK_WORDS = 4
);
    localparam int unsigned OFFSET   = $clog2(BLOCK_WORDS);
    localparam int unsigned TAG_SIZE = 32 - INDEX_SIZE - OFFSET - 2;

    logic                   cpu_req_i;
    logic [31:0]            cpu_address_i;
    logic                   cpu_ready_o;
    logic                   cpu_valid_o;
    logic [PORT_WIDTH-1:0]  cpu_data_o;

    logic                   cache_read_o;
    logic [INDEX_SIZE-1:0]  cache_index_o;
    logic [OFFSET-1:0]      cache_offset_o;
    logic [TAG_SIZE-1:0]    cache_tag_o;
    logic                   cache_hit_i;
    logic [PORT_WIDTH-1:0]  cache_data_i;
    logic                   cache_write_o;
    logic [WAYS_NUMBER-1:0] cache_way_o;
    logic [PORT_WIDTH-1:0]  cache_wdata_o;
    logic                   cache_valid_o;

    logic                   mem_req_o;
    logic [31:0]            mem_address_o;
    logic                   mem_ack_i;
    logic                   mem_data_valid_i;
    logic [PORT_WIDTH-1:0]  mem_data_i;

    modport master (
        input  cpu_req_i, cpu_address_i,
        output cpu_ready_o, cpu_valid_o, cpu_data_o,
        output cache_read_o, cache_index_o, cache_offset_o, cache_tag_o,
        input  cache_hit_i, cache_data_i,
        output cache_write_o, cache_way_o, cache_wdata_o, cache_valid_o,
        output mem_req_o, mem_address_o,
        input  mem_ack_i, mem_data_valid_i, mem_data_i
    );

    modport slave (
        output cpu_req_i, cpu_address_i,
        input  cpu_ready_o, cpu_valid_o, cpu_data_o,
        input  cache_read_o, cache_index_o, cache_offset_o, cache_tag_o,
        output cache_hit_i, cache_data_i,
        input  cache_write_o, cache_way_o, cache_wdata_o, cache_valid_o,
        input  mem_req_o, mem_address_o,
        output mem_ack_i, mem_data_valid_i, mem_data_i
    );
endinterface

// File: rtl/data_cache_port1_controller.sv
// Data cache read-port sequencer: lookup, line refill into a round-robin victim way on miss,
// then replay so every load response is delivered through the hit path.
module data_cache_port1_controller #(
    parameter int unsigned WAYS_NUMBER = 4,
    parameter int unsigned PORT_WIDTH  = 32,
    parameter int unsigned INDEX_SIZE  = 7,
    parameter int unsigned BLOCK_WORDS = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    data_cache_port1_controller_if.master bus
);
    localparam int unsigned OFFSET   = $clog2(BLOCK_WORDS);
    localparam int unsigned TAG_SIZE = 32 - INDEX_SIZE - OFFSET - 2;
    localparam int unsigned IDX_LO   = OFFSET + 2;
    localparam int unsigned TAG_LO   = OFFSET + INDEX_SIZE + 2;
    localparam int unsigned VICTIM_W = $clog2(WAYS_NUMBER);

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        MISS_REQ,
        REFILL,
        REPLAY
    } state_t;

    state_t                state_q, state_d;
    logic [31:2]           addr_q;
    logic [OFFSET-1:0]     beat_q;
    logic [VICTIM_W-1:0]   victim_q;
    logic                  cpu_valid_q;
    logic [PORT_WIDTH-1:0] cpu_data_q;

    logic accept;
    logic refill_beat;
    logic last_beat;
    logic hit_done;
    logic unused_byte_bits;

    assign accept      = (state_q == IDLE) && bus.cpu_req_i;
    assign refill_beat = (state_q == REFILL) && bus.mem_data_valid_i;
    assign last_beat   = (beat_q == OFFSET'(BLOCK_WORDS - 1));
    assign hit_done    = (state_q == COMPARE) && bus.cache_hit_i;
    assign unused_byte_bits = ^bus.cpu_address_i[1:0];

    assign bus.cpu_valid_o   = cpu_valid_q;
    assign bus.cpu_data_o    = cpu_data_q;
    assign bus.cache_wdata_o = bus.mem_data_i;
    assign bus.mem_address_o = {addr_q[31:IDX_LO], {IDX_LO{1'b0}}};

    // State, captured address, beat counter, victim pointer and response registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            beat_q      <= '0;
            victim_q    <= '0;
            cpu_valid_q <= 1'b0;
            cpu_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cpu_valid_q <= hit_done;
            if (hit_done) begin
                cpu_data_q <= bus.cache_data_i;
            end
            if (accept) begin
                addr_q <= bus.cpu_address_i[31:2];
            end
            if ((state_q == MISS_REQ) && bus.mem_ack_i) begin
                beat_q <= '0;
            end else if (refill_beat) begin
                beat_q <= beat_q + OFFSET'(1);
            end
            if (refill_beat && last_beat) begin
                victim_q <= victim_q + VICTIM_W'(1);
            end
        end
    end

    // Next state and array/memory strobes; lookup fields follow the captured address by default.
    always_comb begin
        state_d            = state_q;
        bus.cpu_ready_o    = 1'b0;
        bus.cache_read_o   = 1'b0;
        bus.cache_write_o  = 1'b0;
        bus.cache_valid_o  = 1'b0;
        bus.cache_way_o    = '0;
        bus.mem_req_o      = 1'b0;
        bus.cache_index_o  = addr_q[IDX_LO +: INDEX_SIZE];
        bus.cache_offset_o = addr_q[2 +: OFFSET];
        bus.cache_tag_o    = addr_q[TAG_LO +: TAG_SIZE];

        case (state_q)
            IDLE: begin
                bus.cpu_ready_o = 1'b1;
                if (bus.cpu_req_i) begin
                    bus.cache_read_o   = 1'b1;
                    bus.cache_index_o  = bus.cpu_address_i[IDX_LO +: INDEX_SIZE];
                    bus.cache_offset_o = bus.cpu_address_i[2 +: OFFSET];
                    bus.cache_tag_o    = bus.cpu_address_i[TAG_LO +: TAG_SIZE];
                    state_d            = COMPARE;
                end
            end
            COMPARE: begin
                state_d = bus.cache_hit_i ? IDLE : MISS_REQ;
            end
            MISS_REQ: begin
                bus.mem_req_o = 1'b1;
                if (bus.mem_ack_i) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                bus.cache_offset_o = beat_q;
                if (bus.mem_data_valid_i) begin
                    // Valid bit only set by the final beat so a partial line never hits.
                    bus.cache_write_o = 1'b1;
                    bus.cache_way_o   = WAYS_NUMBER'(1) << victim_q;
                    bus.cache_valid_o = last_beat;
                    if (last_beat) begin
                        state_d = REPLAY;
                    end
                end
            end
            REPLAY: begin
                bus.cache_read_o = 1'b1;
                state_d          = COMPARE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_data_cache_port1_controller.sv
// Scoreboard bench for data_cache_port1_controller: hit-check array model, line-fetch memory model,
// directed load scenarios with hand-computed data, ways and latencies.
module tb_data_cache_port1_controller;
    localparam int unsigned WAYS = 4;
    localparam int unsigned PW   = 32;
    localparam int unsigned IDX  = 7;
    localparam int unsigned BW   = 4;
    localparam int unsigned SETS = 128;

    typedef struct {
        logic [31:0] data;
        bit          miss;
        int unsigned acc;
    } rsp_t;

    typedef struct {
        logic [1:0]  off;
        logic [3:0]  way;
        logic        vbit;
        logic [31:0] wdata;
    } wr_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    data_cache_port1_controller_if #(.WAYS_NUMBER(WAYS), .PORT_WIDTH(PW), .INDEX_SIZE(IDX), .BLOCK_WORDS(BW)) bus ();

    data_cache_port1_controller #(.WAYS_NUMBER(WAYS), .PORT_WIDTH(PW), .INDEX_SIZE(IDX), .BLOCK_WORDS(BW)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial forever #5 clk_i = ~clk_i;

    rsp_t        rq[$];
    wr_t         wq[$];
    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    int unsigned last_beat_cyc = 0;
    int unsigned req_cycles = 0;
    int unsigned rsp_seen = 0;
    int unsigned writes_seen = 0;
    int          ack_delay = 0;
    int          beat_gap = 0;
    logic [3:0]  exp_way = 4'b0001;
    logic [31:0] exp_line = '0;
    logic [6:0]  exp_index = '0;
    logic [20:0] exp_tag = '0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Hit-check model: tag/valid/data array updated by refill writes, answers every read strobe.
    logic        mv [WAYS][SETS];
    logic [20:0] mt [WAYS][SETS];
    logic [31:0] md [WAYS][SETS][BW];
    initial begin : cache_model
        logic        hit;
        logic [31:0] rdata;
        bus.cache_hit_i  = 1'b0;
        bus.cache_data_i = '0;
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++) begin
                mv[w][s] = 1'b0;
                mt[w][s] = '0;
                for (int b = 0; b < BW; b++) md[w][s][b] = '0;
            end
        mv[2][16] = 1'b1;
        mt[2][16] = 21'h55;
        md[2][16][1] = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk_i);
            if (bus.cache_write_o)
                for (int w = 0; w < WAYS; w++)
                    if (bus.cache_way_o[w]) begin
                        mv[w][bus.cache_index_o] = bus.cache_valid_o;
                        mt[w][bus.cache_index_o] = bus.cache_tag_o;
                        md[w][bus.cache_index_o][bus.cache_offset_o] = bus.cache_wdata_o;
                    end
            if (bus.cache_read_o) begin
                hit = 1'b0;
                rdata = '0;
                for (int w = 0; w < WAYS; w++)
                    if (mv[w][bus.cache_index_o] && (mt[w][bus.cache_index_o] == bus.cache_tag_o)) begin
                        hit = 1'b1;
                        rdata = md[w][bus.cache_index_o][bus.cache_offset_o];
                    end
                bus.cache_hit_i  = hit;
                bus.cache_data_i = rdata;
            end
        end
    end

    // Memory model: ack after ack_delay request cycles, then BW beats separated by beat_gap idle cycles.
    int m_phase = 0;
    int m_wait = 0;
    int m_gap = 0;
    int m_beat = 0;
    initial begin : mem_model
        bus.mem_ack_i        = 1'b0;
        bus.mem_data_valid_i = 1'b0;
        bus.mem_data_i       = '0;
        forever begin
            @(posedge clk_i);
            #1;
            bus.mem_ack_i        = 1'b0;
            bus.mem_data_valid_i = 1'b0;
            if (rst_i) begin
                m_phase = 0;
                m_beat  = 0;
                wq.delete();
            end else begin
                if (m_phase == 0 && bus.mem_req_o) begin
                    m_phase = 1;
                    m_wait  = 0;
                end
                if (m_phase == 1) begin
                    if (m_wait == ack_delay) begin
                        bus.mem_ack_i = 1'b1;
                        m_phase = 2;
                        m_gap   = 0;
                        m_beat  = 0;
                    end else begin
                        m_wait++;
                    end
                end else if (m_phase == 2) begin
                    if (m_gap > 0) begin
                        m_gap--;
                    end else begin
                        bus.mem_data_valid_i = 1'b1;
                        bus.mem_data_i = 32'h5000_0000 | (exp_line + 32'(m_beat * 4));
                        wq.push_back('{off: 2'(m_beat), way: exp_way, vbit: (m_beat == BW - 1),
                                       wdata: bus.mem_data_i});
                        if (m_beat == BW - 1) begin
                            last_beat_cyc = cyc;
                            m_phase = 0;
                        end else begin
                            m_beat++;
                            m_gap = beat_gap;
                        end
                    end
                end
            end
        end
    end

    // Monitor: pops the write and response scoreboards whenever the DUT presents them.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (bus.cache_write_o) begin
                writes_seen++;
                checks++;
                if (wq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write offset=%0d way=%b", bus.cache_offset_o, bus.cache_way_o);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("wr_offset", 32'(bus.cache_offset_o), 32'(w.off));
                    chk("wr_way",    32'(bus.cache_way_o),    32'(w.way));
                    chk("wr_valid",  32'(bus.cache_valid_o),  32'(w.vbit));
                    chk("wr_data",   bus.cache_wdata_o,       w.wdata);
                    chk("wr_tag",    32'(bus.cache_tag_o),    32'(exp_tag));
                    chk("wr_index",  32'(bus.cache_index_o),  32'(exp_index));
                end
            end
            if (bus.cpu_valid_o) begin
                rsp_seen++;
                checks++;
                if (rq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_rsp data=0x%08h", bus.cpu_data_o);
                end else begin
                    rsp_t r;
                    r = rq.pop_front();
                    chk("rsp_data", bus.cpu_data_o, r.data);
                    chk(r.miss ? "miss_latency" : "hit_latency", cyc,
                        r.miss ? last_beat_cyc + 3 : r.acc + 2);
                end
            end
            if (bus.mem_req_o) begin
                req_cycles++;
                chk("mem_address", bus.mem_address_o, exp_line);
                chk("ready_during_miss", 32'(bus.cpu_ready_o), 32'd0);
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"},    32'(bus.cpu_ready_o),   32'd1);
        chk({tag, "_valid"},    32'(bus.cpu_valid_o),   32'd0);
        chk({tag, "_data"},     bus.cpu_data_o,         32'd0);
        chk({tag, "_read"},     32'(bus.cache_read_o),  32'd0);
        chk({tag, "_write"},    32'(bus.cache_write_o), 32'd0);
        chk({tag, "_cvalid"},   32'(bus.cache_valid_o), 32'd0);
        chk({tag, "_way"},      32'(bus.cache_way_o),   32'd0);
        chk({tag, "_mem_req"},  32'(bus.mem_req_o),     32'd0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        bus.cpu_req_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        rq.delete();
        req_cycles = 0;
    endtask

    task automatic set_target(input logic [31:0] addr, input logic [3:0] way);
        exp_line  = addr & 32'hFFFF_FFF0;
        exp_index = addr[10:4];
        exp_tag   = addr[31:11];
        exp_way   = way;
    endtask

    // Issue one load, check the accept-cycle lookup, wait for its response and check data hold.
    task automatic do_load(input logic [31:0] addr, input logic [31:0] exp_data, input bit miss,
                           input logic [3:0] way);
        int unsigned n;
        int unsigned target;
        set_target(addr, way);
        target = rsp_seen + 1;
        bus.cpu_req_i = 1'b1;
        bus.cpu_address_i = addr;
        n = 0;
        while (!bus.cpu_ready_o && n < 50) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        chk("accept_ready", 32'(bus.cpu_ready_o), 32'd1);
        rq.push_back('{data: exp_data, miss: miss, acc: cyc});
        #1;
        chk("acc_read",   32'(bus.cache_read_o),   32'd1);
        chk("acc_index",  32'(bus.cache_index_o),  32'(addr[10:4]));
        chk("acc_offset", 32'(bus.cache_offset_o), 32'(addr[3:2]));
        chk("acc_tag",    32'(bus.cache_tag_o),    32'(addr[31:11]));
        @(posedge clk_i);
        #1;
        bus.cpu_req_i = 1'b0;
        bus.cpu_address_i = 32'hFFFF_FFFC;
        n = 0;
        while (rsp_seen < target && n < 300) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        if (rsp_seen < target) begin
            checks++;
            failures++;
            $display("FAIL rsp_timeout addr=0x%08h waited=%0d required=response", addr, n);
        end else begin
            chk("valid_pulse", 32'(bus.cpu_valid_o), 32'd0);
            chk("data_hold",   bus.cpu_data_o,       exp_data);
        end
    endtask

    initial begin : stimulus
        logic [3:0] five_ways [5];
        int unsigned n;
        five_ways = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        bus.cpu_req_i = 1'b0;
        bus.cpu_address_i = '0;

        // reset values, then a preloaded hit
        repeat (2) @(posedge clk_i);
        #1;
        chk_reset_outputs("rst");
        do_reset();
        chk_reset_outputs("post_rst");
        do_load(32'h0002_A904, 32'hDEAD_BEEF, 1'b0, 4'b0001);
        chk("hit_no_mem_req", req_cycles, 32'd0);

        // cold miss: line 0x1230, replay returns beat 2
        do_reset();
        ack_delay = 0;
        beat_gap  = 0;
        do_load(32'h0000_1238, 32'h5000_1238, 1'b1, 4'b0001);
        chk("cold_req_cycles", req_cycles, 32'd1);
        chk("cold_wq_empty", 32'(wq.size()), 32'd0);

        // five misses to set 0x23 walk the victim ways
        do_reset();
        for (int k = 1; k <= 5; k++)
            do_load(32'h0000_1238 + 32'(k) * 32'h800, 32'h5000_1238 + 32'(k) * 32'h800, 1'b1, five_ways[k-1]);
        chk("five_req_cycles", req_cycles, 32'd5);

        // gapped refill beats
        do_reset();
        beat_gap = 3;
        n = writes_seen;
        do_load(32'h0000_4444, 32'h5000_4444, 1'b1, 4'b0001);
        chk("gap_write_count", writes_seen - n, 32'd4);
        chk("gap_wq_empty", 32'(wq.size()), 32'd0);

        // ack held off for 10 cycles
        do_reset();
        beat_gap  = 0;
        ack_delay = 10;
        do_load(32'h0000_8008, 32'h5000_8008, 1'b1, 4'b0001);
        chk("delay_req_cycles", req_cycles, 32'd11);

        // reset after two refill beats, then the same load refills way 0 again
        do_reset();
        ack_delay = 0;
        beat_gap  = 3;
        set_target(32'h0000_C00C, 4'b0001);
        n = writes_seen;
        bus.cpu_req_i = 1'b1;
        bus.cpu_address_i = 32'h0000_C00C;
        @(posedge clk_i);
        #1;
        bus.cpu_req_i = 1'b0;
        for (int i = 0; i < 100 && (writes_seen - n) < 2; i++) begin
            @(posedge clk_i);
            #1;
        end
        chk("abort_beats_before_rst", writes_seen - n, 32'd2);
        rst_i = 1'b1;
        #1;
        chk_reset_outputs("abort");
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        rq.delete();
        do_load(32'h0000_C00C, 32'h5000_C00C, 1'b1, 4'b0001);
        chk("abort_wq_empty", 32'(wq.size()), 32'd0);

        repeat (3) @(posedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
